// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types and helpers for the serial-in/parallel-out deserializer
//   state_e  : receive FSM states
//   cnt_w()  : bit counter width for a given word width
package sipo_pkg;

    typedef enum logic {ST_IDLE, ST_RECV} state_e;

    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: collects WIDTH serial bits into a word, offers it on a valid/ready port
//   clk, reset          : clock, asynchronous active-high reset
//   din, din_valid      : serial bit and its strobe
//   frame_start         : with din_valid, marks bit 0 of a new word
//   dout, dout_valid    : held word and its valid flag
//   out_ready           : consumer pops the held word
//   overflow            : sticky, a completed word was dropped
//   clr_overflow        : synchronous clear of overflow (a new drop wins)
//   busy                : a partial word is being assembled
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             out_ready,
    output logic             overflow,
    input  logic             clr_overflow,
    output logic             busy
);

    localparam int CW = cnt_w(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             hvld_q, hvld_d;
    logic             ovf_q, ovf_d;

    logic             start, done, pop, store;
    logic [WIDTH-1:0] base, word;

    // A bit in IDLE or a frame_start bit begins a fresh word from an empty shifter.
    assign start = din_valid & ((state_q == ST_IDLE) | frame_start);
    assign done  = din_valid & (state_q == ST_RECV) & ~frame_start & (cnt_q == CW'(WIDTH - 1));
    assign base  = start ? '0 : shift_q;
    assign word  = MSB_FIRST ? {base[WIDTH-2:0], din} : {din, base[WIDTH-1:1]};
    assign pop   = hvld_q & out_ready;
    // A pop in the completion cycle frees the holding register for the new word.
    assign store = done & (~hvld_q | pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (din_valid) state_d = done ? ST_IDLE : ST_RECV;
    end

    always_comb begin
        busy = (state_q == ST_RECV);
    end

    always_comb begin
        shift_d = din_valid ? word : shift_q;
        cnt_d   = !din_valid ? cnt_q : start ? CW'(1) : done ? '0 : CW'(cnt_q + 1'b1);
        hold_d  = store ? word : hold_q;
        hvld_d  = store | (hvld_q & ~pop);
        ovf_d   = (done & ~store) | (ovf_q & ~clr_overflow);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            hvld_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            hvld_q  <= hvld_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dout       = hold_q;
    assign dout_valid = hvld_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed checks of an MSB-first and an LSB-first deserializer
module tb_sipo_deserializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       din = 1'b0, din_valid = 1'b0, frame_start = 1'b0;
    logic       out_ready = 1'b0, clr_overflow = 1'b0;
    logic [7:0] dout_a, dout_b;
    logic       vld_a, vld_b, ovf_a, ovf_b, busy_a, busy_b;
    int         n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .frame_start(frame_start),
        .dout(dout_a), .dout_valid(vld_a), .out_ready(out_ready), .overflow(ovf_a),
        .clr_overflow(clr_overflow), .busy(busy_a)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .frame_start(frame_start),
        .dout(dout_b), .dout_valid(vld_b), .out_ready(out_ready), .overflow(ovf_b),
        .clr_overflow(clr_overflow), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fs);
        din         = b;
        frame_start = fs;
        din_valid   = 1'b1;
        tick();
    endtask

    task automatic idle();
        din_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic fs);
        for (int i = 7; i >= 0; i--) send_bit(w[i], (i == 7) ? fs : 1'b0);
    endtask

    initial begin
        logic [7:0] s1;
        logic [7:0] w5;
        int         nbusy;
        #2;
        check("rst_dout", dout_a, 8'h00);
        check("rst_vld", vld_a, 1'b0);
        check("rst_ovf", ovf_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;

        s1 = 8'hA5;
        nbusy = 0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(s1[i], 1'b0);
            if (i > 0) check("t1_busy", busy_a, 1'b1);
            nbusy += int'(busy_a);
        end
        check("t1_busy_cnt", nbusy, 7);
        check("t1_vld", vld_a, 1'b1);
        check("t1_dout_a", dout_a, 8'hA5);
        check("t1_dout_b", dout_b, 8'hA5);
        idle();
        tick();
        check("t1_pulse", vld_a, 1'b0);

        send_word(8'hC0, 1'b0);
        check("t2_dout_a", dout_a, 8'hC0);
        check("t2_dout_b", dout_b, 8'h03);
        idle();
        tick();

        out_ready = 1'b0;
        send_word(8'h3C, 1'b0);
        check("t3_vld1", vld_a, 1'b1);
        check("t3_dout1", dout_a, 8'h3C);
        check("t3_ovf1", ovf_a, 1'b0);
        send_word(8'hC3, 1'b0);
        check("t3_dout2", dout_a, 8'h3C);
        check("t3_ovf2", ovf_a, 1'b1);
        check("t3_ovf2_b", ovf_b, 1'b1);
        idle();
        out_ready = 1'b1;
        tick();
        check("t3_pop", vld_a, 1'b0);
        check("t3_sticky", ovf_a, 1'b1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("t3_clr", ovf_a, 1'b0);

        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            send_bit(i == 7 || i == 0, i == 7);
            if (i > 0) check("t4_novld", vld_a, 1'b0);
        end
        check("t4_vld", vld_a, 1'b1);
        check("t4_dout", dout_a, 8'h81);
        check("t4_ovf", ovf_a, 1'b0);
        idle();
        tick();

        out_ready = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            w5 = 8'(w);
            for (int i = 7; i >= 0; i--) begin
                out_ready = (i == 0) && (w > 1);
                send_bit(w5[i], 1'b0);
                if (i == 7) check("t5_busy", busy_a, 1'b1);
            end
            out_ready = 1'b0;
            check("t5_vld", vld_a, 1'b1);
            check("t5_dout_a", dout_a, 32'(w5));
            check("t5_dout_b", dout_b, 32'({w5[0], w5[1], w5[2], w5[3], w5[4], w5[5], w5[6], w5[7]}));
            check("t5_ovf", ovf_a, 1'b0);
        end
        idle();
        out_ready = 1'b1;
        tick();
        check("t5_drain", vld_a, 1'b0);

        out_ready = 1'b0;
        send_word(8'h77, 1'b0);
        check("t6_vld", vld_a, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        idle();
        check("t6_busy", busy_a, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_dout", dout_a, 8'h00);
        check("t6_rst_vld", vld_a, 1'b0);
        check("t6_rst_busy", busy_a, 1'b0);
        check("t6_rst_ovf", ovf_a, 1'b0);
        tick();
        tick();
        #2;
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        send_word(8'h5A, 1'b0);
        check("t6_vld2", vld_a, 1'b1);
        check("t6_dout_a", dout_a, 8'h5A);
        check("t6_dout_b", dout_b, 8'h5A);
        check("t6_ovf", ovf_a, 1'b0);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
